vram_frame_reader: RTL and testbench
====================================

// Module: vram_frame_reader
// PURPOSE
//  Parametrised VRAM scan-out engine: on a start pulse, walks a rectangular window of the
//  framebuffer in raster order, issues one read per pixel and streams pixels out over a
//  valid/ready interface with a last flag and a done pulse. Replaces free-running address
//  counters on the GPU side; tolerates downstream backpressure without dropping pixels.
// PARAMETERS
//  ADDR_W    32   VRAM address width
//  PIX_W     8    pixel width (bits)
//  DIM_W     16   width of window coordinate/size fields
//  STRIDE    256  pixels per framebuffer row
//  BASE_ADDR 0    VRAM address of pixel (0,0)
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  reset      in   1       synchronous, active-high
//  start      in   1       pulse; sampled only when busy=0
//  win_x      in   DIM_W   window left column (sampled with start)
//  win_y      in   DIM_W   window top row (sampled with start)
//  win_w      in   DIM_W   window width in pixels (sampled with start)
//  win_h      in   DIM_W   window height in rows (sampled with start)
//  vram_rd    out  1       read strobe, one pixel per asserted cycle
//  vram_addr  out  ADDR_W  read address, valid when vram_rd=1
//  vram_data  in   PIX_W   read data, valid exactly 1 cycle after vram_rd
//  pix_data   out  PIX_W   output pixel
//  pix_valid  out  1       pix_data valid
//  pix_ready  in   1       downstream accepts when pix_valid&pix_ready
//  pix_last   out  1       qualifies final pixel of window (with pix_valid)
//  busy       out  1       transfer in progress
//  done       out  1       one-cycle completion pulse
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; counters, 2-entry output FIFO, in-flight flag cleared.
//    Reset mid-transfer aborts immediately; in-flight read data discarded, no done pulse.
//  - FSM: IDLE -start-> RUN (issue reads) -last read issued-> DRAIN (FIFO empties)
//    -last pixel accepted-> DONE (done=1, one cycle) -> IDLE. start while busy: ignored.
//  - win_w==0 or win_h==0: IDLE->DONE directly; done pulses cycle after start; no reads,
//    no pixels; busy=1 only in the DONE cycle.
//  - busy=1 in RUN, DRAIN and DONE.
//  - Address: BASE_ADDR + (win_y+row)*STRIDE + (win_x+col), computed in ADDR_W bits,
//    wraps modulo 2^ADDR_W; no bounds check. col runs 0..win_w-1, then row++ and col=0.
//  - Timing: start sampled at edge k -> first vram_rd in cycle k+1 -> vram_data in k+2,
//    written to FIFO at end of k+2 -> first pix_valid in cycle k+3.
//  - Flow control: read issued in a cycle iff RUN and (FIFO entries + outstanding read
//    - pop this cycle) < 2. FIFO never overflows; with pix_ready held 1, one pixel/cycle.
//  - pix_valid=1 whenever FIFO non-empty; pix_data/pix_last stable while valid&!ready.
//  - pix_last=1 only on pixel index win_w*win_h-1; FIFO stores last bit alongside data.
//  - done asserted the cycle after pix_valid&pix_ready&pix_last; busy drops with done.
//  - Window registers latched at start; input changes during busy have no effect.
// TESTING
//  1 reset, start, win=(0,0,4,1), ready=1, vram_data=addr[7:0] -> vram_addr 0,1,2,3 in
//    cycles k+1..k+4; pix_data 0,1,2,3 in k+3..k+6; pix_last on 3; done at k+7.
//  2 win=(2,3,2,2), STRIDE=256 -> vram_addr 770,771,1026,1027 in order; 4 pixels; 1 done.
//  3 win=(0,0,8,1), pix_ready toggled 1/0 each cycle -> all 8 pixels in order, none lost
//    or duplicated, pix_data held stable while stalled; never >2 reads outstanding+stored.
//  4 win_w=0 -> no vram_rd, no pix_valid, done one cycle after start.
//  5 start pulsed again mid-transfer with other window -> ignored; original window completes.
//  6 reset asserted after 3 of 16 pixels -> next cycle all outputs 0; new start restarts
//    from window origin with no stale pixel emitted.

Source files
------------

// File: rtl/vram_frame_reader.sv
// Raster-order VRAM window scan-out: one read per pixel, 2-entry skid FIFO,
// valid/ready pixel stream with last flag and a one-cycle done pulse.
module vram_frame_reader #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned DIM_W     = 16,
  parameter int unsigned STRIDE    = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  win_x,
  input  logic [DIM_W-1:0]  win_y,
  input  logic [DIM_W-1:0]  win_w,
  input  logic [DIM_W-1:0]  win_h,
  output logic              vram_rd,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [PIX_W-1:0]  vram_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q;
  logic [DIM_W-1:0]  win_x_q, win_w_q, win_h_q;
  logic [DIM_W-1:0]  col_q, row_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              inflight_q, inflight_last_q;
  logic [PIX_W-1:0]  fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic              pop, issue, col_end, last_rd;
  logic [2:0]        occ;

  always_comb begin
    pix_valid = (count_q != 2'd0);
    pop       = pix_valid & pix_ready;
    // Stored plus outstanding, minus what leaves this cycle, must stay below 2.
    occ       = {1'b0, count_q} + {2'b0, inflight_q};
    issue     = (state_q == StRun) && (occ < (3'd2 + {2'b0, pop}));
    col_end   = (col_q == win_w_q - DIM_W'(1));
    last_rd   = col_end && (row_q == win_h_q - DIM_W'(1));
    vram_rd   = issue;
    vram_addr = issue ? (row_base_q + ADDR_W'(win_x_q) + ADDR_W'(col_q)) : '0;
    pix_data  = pix_valid ? fifo_data_q[rd_ptr_q] : '0;
    pix_last  = pix_valid & fifo_last_q[rd_ptr_q];
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      win_x_q         <= '0;
      win_w_q         <= '0;
      win_h_q         <= '0;
      col_q           <= '0;
      row_q           <= '0;
      row_base_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue & last_rd;
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= vram_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};

      unique case (state_q)
        StIdle: begin
          if (start) begin
            win_x_q    <= win_x;
            win_w_q    <= win_w;
            win_h_q    <= win_h;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(win_y) * ADDR_W'(STRIDE);
            state_q    <= ((win_w == '0) || (win_h == '0)) ? StDone : StRun;
          end
        end
        StRun: begin
          if (issue) begin
            if (last_rd) begin
              state_q <= StDrain;
            end else if (col_end) begin
              col_q      <= '0;
              row_q      <= row_q + DIM_W'(1);
              row_base_q <= row_base_q + ADDR_W'(STRIDE);
            end else begin
              col_q <= col_q + DIM_W'(1);
            end
          end
        end
        StDrain: if (pop && pix_last) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_frame_reader.sv
// Randomised bench for vram_frame_reader: a window-level reference model (address and
// pixel queues) checked every cycle, plus literal checks on the directed windows.
module tb_vram_frame_reader;

  localparam int unsigned STRIDE = 256;
  localparam int unsigned BASE   = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] win_x = '0, win_y = '0, win_w = '0, win_h = '0;
  logic        vram_rd;
  logic [31:0] vram_addr;
  logic [7:0]  vram_data = '0;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_last;
  logic        busy;
  logic        done;

  vram_frame_reader #(
    .ADDR_W(32), .PIX_W(8), .DIM_W(16), .STRIDE(STRIDE), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_data(vram_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [31:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // VRAM: data one cycle after a read strobe, garbage otherwise.
  always @(posedge clk) begin
    if (vram_rd) vram_data <= mem_f(vram_addr);
    else         vram_data <= 8'($urandom);
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] exp_addr [$];
  logic [7:0]  exp_pd [$];
  bit          exp_pl [$];
  logic [31:0] rd_log [$];
  logic [7:0]  acc_log [$];
  bit  armed = 0, m_busy = 0, m_done = 0;
  int  outst = 0, cyc = 0, done_cnt = 0;
  int  start_cyc = -1, first_rd = -1, first_pv = -1, done_cyc = -1;
  bit  pop_now, popped_last, accept;

  task automatic load_window(input int x, input int y, input int w, input int h);
    logic [31:0] a;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        a = 32'(BASE) + 32'(y + r) * 32'(STRIDE) + 32'(x + c);
        exp_addr.push_back(a);
        exp_pd.push_back(mem_f(a));
        exp_pl.push_back((r == h - 1) && (c == w - 1));
      end
  endtask

  always @(negedge clk) begin
    if (!armed) begin
      if (reset) armed = 1;
    end else begin
      cyc++;
      pop_now = pix_valid && pix_ready;
      popped_last = 0;
      check("busy", busy, m_busy);
      check("done", done, m_done);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (vram_rd) begin
        if (first_rd < 0) first_rd = cyc;
        rd_log.push_back(vram_addr);
        if (exp_addr.size() == 0) check("spurious_rd", 1, 0);
        else check("vram_addr", vram_addr, exp_addr.pop_front());
        check("occupancy_le2", ((outst + 1 - (pop_now ? 1 : 0)) <= 2) ? 1 : 0, 1);
      end
      if (pix_valid) begin
        if (first_pv < 0) first_pv = cyc;
        if (exp_pd.size() == 0) check("spurious_pix", 1, 0);
        else begin
          check("pix_data", pix_data, exp_pd[0]);
          check("pix_last", pix_last, exp_pl[0]);
          if (pop_now) begin
            popped_last = exp_pl[0];
            acc_log.push_back(pix_data);
            void'(exp_pd.pop_front());
            void'(exp_pl.pop_front());
          end
        end
      end
      if (reset) begin
        exp_addr.delete(); exp_pd.delete(); exp_pl.delete();
        m_busy = 0; m_done = 0; outst = 0;
      end else begin
        outst += (vram_rd ? 1 : 0) - (pop_now ? 1 : 0);
        accept = start && !m_busy;
        if (m_done) m_busy = 0;
        if (accept) begin
          m_busy = 1;
          start_cyc = cyc;
          load_window(int'(win_x), int'(win_y), int'(win_w), int'(win_h));
        end
        m_done = popped_last || (accept && (win_w == 0 || win_h == 0));
      end
    end
  end

  // mode: 0 ready held high, 1 toggling, 2 random
  task automatic run_window(input int x, input int y, input int w, input int h,
                            input int mode, input bit mid);
    int d0;
    bit got;
    @(posedge clk); #1;
    rd_log.delete(); acc_log.delete();
    start_cyc = -1; first_rd = -1; first_pv = -1; done_cyc = -1;
    d0 = done_cnt;
    start = 1; win_x = 16'(x); win_y = 16'(y); win_w = 16'(w); win_h = 16'(h);
    pix_ready = 1;
    @(posedge clk); #1;
    start = 0;
    win_x = 16'($urandom); win_y = 16'($urandom); win_w = 16'($urandom); win_h = 16'($urandom);
    got = 0;
    for (int i = 0; i < 400; i++) begin
      if (done_cnt != d0) begin got = 1; break; end
      if (mid && i == 4) begin
        start = 1; win_x = 100; win_y = 100; win_w = 3; win_h = 3;
      end else start = 0;
      pix_ready = (mode == 0) ? 1'b1 : (mode == 1) ? i[0] : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 0;
    pix_ready = 1;
    check("done_seen", got, 1);
    check("done_count", done_cnt - d0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // 1: basic latency and ordering
    run_window(0, 0, 4, 1, 0, 0);
    check("t1_first_rd_lat", first_rd - start_cyc, 1);
    check("t1_first_pv_lat", first_pv - start_cyc, 3);
    check("t1_done_lat", done_cyc - start_cyc, 7);
    check("t1_npix", acc_log.size(), 4);
    for (int i = 0; i < acc_log.size(); i++) check("t1_pix", acc_log[i], i);

    // 2: offset window across two rows
    run_window(2, 3, 2, 2, 0, 0);
    check("t2_nrd", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      check("t2_addr0", rd_log[0], 770);
      check("t2_addr1", rd_log[1], 771);
      check("t2_addr2", rd_log[2], 1026);
      check("t2_addr3", rd_log[3], 1027);
    end
    check("t2_npix", acc_log.size(), 4);

    // 3: toggling backpressure
    run_window(0, 0, 8, 1, 1, 0);
    check("t3_npix", acc_log.size(), 8);
    for (int i = 0; i < acc_log.size(); i++) check("t3_pix", acc_log[i], i);

    // 4: empty window
    run_window(7, 7, 0, 3, 0, 0);
    check("t4_nrd", rd_log.size(), 0);
    check("t4_done_lat", done_cyc - start_cyc, 1);

    // 5: restart attempt while busy is ignored
    run_window(5, 1, 6, 2, 2, 1);
    check("t5_nrd", rd_log.size(), 12);
    if (rd_log.size() == 12) begin
      check("t5_first_addr", rd_log[0], 261);
      check("t5_last_addr", rd_log[11], 522);
    end

    // 6: reset mid-transfer, then restart
    @(posedge clk); #1;
    acc_log.delete();
    start = 1; win_x = 0; win_y = 2; win_w = 16; win_h = 1; pix_ready = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 100 && acc_log.size() < 3; i++) begin
      pix_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("t6_pre_reset_pix", acc_log.size(), 3);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    bad = int'(vram_rd) + int'(vram_addr != 0) + int'(pix_valid) + int'(pix_data != 0)
        + int'(pix_last) + int'(busy) + int'(done);
    check("t6_outputs_zero_after_reset", bad, 0);
    run_window(0, 2, 16, 1, 2, 0);
    check("t6_npix", acc_log.size(), 16);
    if (acc_log.size() > 0) check("t6_first_pix", acc_log[0], 2);

    // Random windows, random backpressure
    for (int n = 0; n < 25; n++) begin
      run_window($urandom_range(0, 400), $urandom_range(0, 65535), $urandom_range(0, 6),
                 $urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
